// File: rtl/fetch_pc_unit_if.sv
// Fetch-side bundle: instruction memory read port plus decode handshake.
// master = fetch unit, slave = memory/decode side.
interface fetch_pc_unit_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_o;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ack_i,
        input  imem_rdata_i,
        output instr_o,
        output instr_valid_o,
        input  instr_ready_i,
        output pc_o,
        output pc_plus4_o
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ack_i,
        output imem_rdata_i,
        input  instr_o,
        input  instr_valid_o,
        output instr_ready_i,
        input  pc_o,
        input  pc_plus4_o
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Instruction fetch / PC stage: one outstanding imem read, valid/ready to decode.
// Define PC_MISALIGN_CHECK_EN to halt on misaligned redirect targets.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    fetch_pc_unit_if.master bus,
    input  logic            ex_valid_i,
    input  logic            ex_branch_i,
    input  logic            ex_jal_i,
    input  logic            ex_jalr_i,
    input  logic            ex_flag_i,
    input  logic [31:0]     ex_result_i,
    input  logic [31:0]     ex_pc_i,
    input  logic [31:0]     ex_imm_i,
    output logic            misalign_o
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        HOLD,
        DRAIN,
        HALT
    } state_e;

    state_e      state_q;
    logic        req_q;
    logic        valid_q;
    logic        mis_q;
    logic [31:0] fpc_q;
    logic [31:0] tgt_q;
    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic [31:0] pc4_q;

    logic        redir;
    logic        bad;
    logic [31:0] tgt_raw;
    logic [31:0] tgt;

    assign redir = ex_valid_i
                 & ((ex_branch_i & ex_flag_i) | ex_jal_i | ex_jalr_i);

    assign tgt_raw = ex_jalr_i ? (ex_result_i & ~32'h1)
                               : (ex_pc_i + ex_imm_i);

`ifdef PC_MISALIGN_CHECK_EN
    assign tgt = tgt_raw;
    assign bad = redir & (tgt_raw[1:0] != 2'b00);
`else
    assign tgt = tgt_raw & ~32'h3;
    assign bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            fpc_q   <= RESET_PC;
            tgt_q   <= RESET_PC;
            instr_q <= 32'h0;
            pc_q    <= RESET_PC;
            pc4_q   <= RESET_PC + 32'd4;
        end else if (bad) begin
            // Misaligned target: stop issuing, abandon any request.
            state_q <= HALT;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            mis_q   <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                    if (redir) fpc_q <= tgt;
                end
                FETCH: begin
                    if (redir && bus.imem_ack_i) begin
                        fpc_q <= tgt;
                    end else if (redir) begin
                        state_q <= DRAIN;
                        tgt_q   <= tgt;
                    end else if (bus.imem_ack_i) begin
                        state_q <= HOLD;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                        instr_q <= bus.imem_rdata_i;
                        pc_q    <= fpc_q;
                        pc4_q   <= fpc_q + 32'd4;
                    end
                end
                HOLD: begin
                    if (redir || bus.instr_ready_i) begin
                        state_q <= FETCH;
                        req_q   <= 1'b1;
                        valid_q <= 1'b0;
                        fpc_q   <= redir ? tgt : pc4_q;
                    end
                end
                DRAIN: begin
                    if (redir) tgt_q <= tgt;
                    // Latest redirect wins, even on the draining ack edge.
                    if (bus.imem_ack_i) begin
                        state_q <= FETCH;
                        fpc_q   <= redir ? tgt : tgt_q;
                    end
                end
                HALT: state_q <= HALT;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.imem_req_o    = req_q;
    assign bus.imem_addr_o   = fpc_q;
    assign bus.instr_o       = instr_q;
    assign bus.instr_valid_o = valid_q;
    assign bus.pc_o          = pc_q;
    assign bus.pc_plus4_o    = pc4_q;
    assign misalign_o        = mis_q;

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch and program-counter stage of the RISC_V CPU, directly upstream of decode and the ALU. It owns the PC, issues single-beat reads to instruction memory and presents each fetched word to decode with a valid/ready handshake. It consumes the execute stage's branch outcome (the ALU `Flag`) and jump target (the ALU `Result` for JALR) to redirect the PC.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset; must be word-aligned.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req_o` out 1: read request; held high until `imem_ack_i`.
- `imem_addr_o` out 32: read address; stable while `imem_req_o` is high.
- `imem_ack_i` in 1: read data valid this cycle; only meaningful while `imem_req_o` is high.
- `imem_rdata_i` in 32: instruction word, sampled when `imem_ack_i` is high.
- `instr_o` out 32: fetched instruction to decode.
- `instr_valid_o` out 1: `instr_o`, `pc_o` and `pc_plus4_o` are valid.
- `instr_ready_i` in 1: decode accepts the instruction.
- `pc_o` out 32: PC of `instr_o`.
- `pc_plus4_o` out 32: `pc_o + 4`, the link value for JAL/JALR.
- `ex_valid_i` in 1: execute-stage control inputs below are valid this cycle.
- `ex_branch_i`, `ex_jal_i`, `ex_jalr_i` in 1 each: instruction class in execute; at most one is high.
- `ex_flag_i` in 1: ALU branch-condition flag.
- `ex_result_i` in 32: ALU result, used as the JALR target.
- `ex_pc_i` in 32: PC of the instruction in execute.
- `ex_imm_i` in 32: sign-extended immediate of that instruction.
- `misalign_o` out 1: misaligned redirect target detected (see Configuration).

## Operation
- Redirect fires when `ex_valid_i & ((ex_branch_i & ex_flag_i) | ex_jal_i | ex_jalr_i)`.
- Target for branch/JAL is `ex_pc_i + ex_imm_i`, modulo 2^32. Target for JALR is `ex_result_i & ~32'h1`.
- States:
  - IDLE: entered on reset. Moves to FETCH on the next edge.
  - FETCH: `imem_req_o` = 1 with `imem_addr_o` = fetch PC. On ack with no redirect, latch `imem_rdata_i` into `instr_o` and the fetch PC into `pc_o`, then go to HOLD.
  - HOLD: `instr_valid_o` = 1. On `instr_ready_i`, fetch PC becomes `pc_o + 4` and the unit returns to FETCH.
  - DRAIN: a request is outstanding but its data is discarded. `imem_req_o` stays high at the old address. On ack, go to FETCH at the stored redirect target.
  - HALT: only when the macro is enabled. `misalign_o` = 1, no requests. Reset is the only exit.
- Redirect has priority over every other event:
  - In FETCH without ack: go to DRAIN and store the target.
  - In FETCH with ack in the same cycle: drop the data and go to FETCH at the target.
  - In HOLD, whether or not ready is high: drop the instruction and go to FETCH at the target.
  - In DRAIN: overwrite the stored target, so the latest target wins.
  - In IDLE: go to FETCH at the target.
- Only one request is ever outstanding; there is no prefetch.

## Timing
- Reset values:
  - outputs: `imem_req_o` = 0, `imem_addr_o` = `RESET_PC`, `instr_o` = 0, `instr_valid_o` = 0, `pc_o` = `RESET_PC`, `pc_plus4_o` = `RESET_PC + 4`, `misalign_o` = 0;
  - internal: state IDLE, fetch PC `RESET_PC`.
- All outputs are registered. `pc_plus4_o` is always `pc_o + 4`.
- Reset deasserted at edge 0: `imem_req_o` goes high after edge 1.
- Ack sampled at edge N: `instr_valid_o` high after edge N, in the same cycle `imem_req_o` drops.
- Handshake at edge M: `instr_valid_o` low and `imem_req_o` high after edge M. Best-case throughput is one instruction per 2 cycles with zero-wait memory.
- Redirect sampled at edge R: `instr_valid_o` is low after edge R. The request to the target is asserted after edge R, or after the draining ack edge if the unit was in DRAIN.
- Asynchronous reset mid-request drops the request immediately. Memory must tolerate an abandoned request.

## Configuration
- `PC_MISALIGN_CHECK_EN` defined: a redirect target with `target[1:0] != 0` does not redirect. The unit enters HALT with `instr_valid_o` = 0 and `misalign_o` = 1, held until reset.
- `PC_MISALIGN_CHECK_EN` undefined: `target[1:0]` is forced to `2'b00` and `misalign_o` is tied to 0.

## Test plan
- Sequential fetch: reset with `RESET_PC`=0, ack one cycle after each request, ready always high. Expect addresses 0, 4, 8, 12 and `pc_plus4_o` = `pc_o + 4` for each.
- Backpressure: ready low for 5 cycles in HOLD. `instr_o`/`pc_o` stay stable and no new request is made. One instruction is delivered when ready rises.
- Taken branch: `ex_pc_i`=0x10, `ex_imm_i`=0xFFFF_FFF8, flag=1 while the unit is in HOLD. The instruction is dropped and the next request address is 0x08. The same stimulus with flag=0 causes no redirect.
- JALR during DRAIN: `ex_result_i`=0x101 while a request to 0x20 is pending with ack delayed 3 cycles. The 0x20 data is discarded and the next request address is 0x100.
- Misalign (macro on): JAL target 0x102. `misalign_o`=1, no further requests until `rst_n` is pulsed. With the macro off, the next request address is 0x100.
- Async reset asserted mid-FETCH: `imem_req_o` and `instr_valid_o` drop without waiting for `clk`, and fetch restarts at `RESET_PC`.
